multi_timer: RTL

- Memory-mapped N-channel timer for the single-cycle/pipelined MIPS datapath.
- Holds one free-running cycle counter and NUM_CH compare channels; each channel is either one-shot or periodic.
- Each channel has a sticky pending bit that drives its interrupt line. Software clears pending bits through a write-1-to-clear acknowledge register.
- Read data and an address-hit flag feed the datapath's memory read mux.

---
 rtl/multi_timer_pkg.sv | 25 ++
 rtl/timer_channel.sv | 68 ++++++
 rtl/multi_timer.sv | 94 +++++++++
 3 files changed

// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer_pkg
// Brief    : Register-window offsets and decode helper for multi_timer.
// Revision : 1.0
// ============================================================================
package multi_timer_pkg;

    localparam int WINDOW_SIZE = 64;
    localparam int WIN_BITS    = $clog2(WINDOW_SIZE);

    localparam logic [5:0] OFF_CYCLE   = 6'h00;
    localparam logic [5:0] OFF_ACK     = 6'h04;
    localparam logic [5:0] OFF_STATUS  = 6'h08;
    localparam logic [5:0] OFF_CTRL    = 6'h0C;
    localparam logic [5:0] OFF_CH_BASE = 6'h10;
    localparam int         CH_STRIDE   = 8;

    // One extra bit so channels placed past the window never alias an offset.
    function automatic logic [6:0] ch_offset(input int ch);
        return 7'(int'(OFF_CH_BASE) + CH_STRIDE * ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Brief    : One compare channel: compare/period registers, armed and sticky pending.
// Revision : 1.0
// ============================================================================
module timer_channel #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_cycle,
    input  logic             i_enable,
    input  logic             i_compare_wr,
    input  logic             i_period_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ack,
    output logic             o_pending,
    output logic [WIDTH-1:0] o_compare,
    output logic [WIDTH-1:0] o_period
);

    logic [WIDTH-1:0] compare_q, compare_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic             w_fire;

    assign w_fire = i_enable & armed_q & (i_cycle == compare_q);

    // A software compare write takes priority over the periodic reload.
    always_comb begin
        compare_d = compare_q;
        armed_d   = armed_q;
        period_d  = i_period_wr ? i_wdata : period_q;
        pending_d = w_fire | (pending_q & ~i_ack);
        if (i_compare_wr) begin
            compare_d = i_wdata;
            armed_d   = 1'b1;
        end else if (w_fire) begin
            if (period_q != '0) begin
                compare_d = compare_q + period_q;
            end else begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            compare_q <= '1;
            period_q  <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            compare_q <= compare_d;
            period_q  <= period_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;
    assign o_compare = compare_q;
    assign o_period  = period_q;

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer
// Brief    : Memory-mapped free-running counter with NUM_CH compare channels.
// Revision : 1.0
// ============================================================================
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       data,
    input  logic [31:0]       address,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       rdata,
    output logic              TimerAddress,
    output logic              TimerInterrupt,
    output logic [NUM_CH-1:0] irq
);

    logic [WIDTH-1:0]    cycle_q, cycle_d;
    logic [NUM_CH-1:0]   ctrl_q, ctrl_d;
    logic [WIN_BITS-1:0] w_off;
    logic                w_wr;
    logic [NUM_CH-1:0]   w_pending;
    logic [WIDTH-1:0]    w_compare [NUM_CH];
    logic [WIDTH-1:0]    w_period  [NUM_CH];

    assign w_off        = address[WIN_BITS-1:0];
    assign TimerAddress = (address[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) &&
                          (address[1:0] == 2'b00) && (MemRead || MemWrite);
    assign w_wr         = TimerAddress & MemWrite;

    always_comb begin
        cycle_d = cycle_q + WIDTH'(1);
        ctrl_d  = (w_wr && w_off == OFF_CTRL) ? data[NUM_CH-1:0] : ctrl_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            ctrl_q  <= '0;
        end else begin
            cycle_q <= cycle_d;
            ctrl_q  <= ctrl_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .i_cycle      (cycle_q),
            .i_enable     (ctrl_q[i]),
            .i_compare_wr (w_wr && ({1'b0, w_off} == ch_offset(i))),
            .i_period_wr  (w_wr && ({1'b0, w_off} == ch_offset(i) + 7'd4)),
            .i_wdata      (data[WIDTH-1:0]),
            .i_ack        (w_wr && (w_off == OFF_ACK) && data[i]),
            .o_pending    (w_pending[i]),
            .o_compare    (w_compare[i]),
            .o_period     (w_period[i])
        );
    end

    // Offsets inside the window with no backing register fall through as 0.
    always_comb begin
        rdata = '0;
        if (TimerAddress && MemRead) begin
            case (w_off)
                OFF_CYCLE:  rdata = 32'(cycle_q);
                OFF_STATUS: rdata = 32'(w_pending);
                OFF_CTRL:   rdata = 32'(ctrl_q);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if ({1'b0, w_off} == ch_offset(i))         rdata = 32'(w_compare[i]);
                        if ({1'b0, w_off} == ch_offset(i) + 7'd4)  rdata = 32'(w_period[i]);
                    end
                end
            endcase
        end
    end

    assign irq            = w_pending;
    assign TimerInterrupt = |w_pending;

endmodule
`default_nettype wire
